// File: rtl/prbs_lfsr_checker_if.sv
// Receive-side PRBS checker bus: serial bit in with valid/clear, lock/error status out.
// The master drives the line bit; the slave is the checker.
interface prbs_lfsr_checker_if #(
    parameter int CNT_W = 16
);
    logic             din;
    logic             din_valid;
    logic             clr;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic [31:0]      bit_cnt;

    modport master (
        output din, din_valid, clr,
        input  locked, err, err_cnt, bit_cnt
    );

    modport slave (
        input  din, din_valid, clr,
        output locked, err, err_cnt, bit_cnt
    );
endinterface

// File: rtl/prbs_lfsr_checker.sv
// Self-synchronising checker for an 8-bit Fibonacci LFSR stream: hunts for lock on the
// received history, then flags and counts mispredicted bits while locked.
module prbs_lfsr_checker #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = 8'b10111000,
    parameter int               LOCK_GOOD = 16,
    parameter int               LOSS_ERR  = 4,
    parameter int               CNT_W     = 16
) (
    input logic              clk,
    input logic              rst,
    prbs_lfsr_checker_if.slave bus
);
    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
    localparam int BAD_W  = $clog2(LOSS_ERR + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_GOOD - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(LOSS_ERR - 1);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  h, h_nxt;
    logic [FILL_W-1:0] fill, fill_nxt;
    logic [GOOD_W-1:0] good, good_nxt;
    logic [BAD_W-1:0]  bad, bad_nxt;
    logic              err_nxt, inc_err, inc_bit;
    logic              err_p1;
    logic [CNT_W-1:0]  err_cnt;
    logic [31:0]       bit_cnt;
    logic [WIDTH-1:0]  tap_win;
    logic              pred, mismatch;

    function automatic logic [CNT_W-1:0] sat_inc_err(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [31:0] sat_inc_bit(input logic [31:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign tap_win  = h & TAPS;
    assign pred     = ^tap_win;
    assign mismatch = bus.din ^ pred;

    always_comb begin
        state_nxt = state;
        h_nxt     = h;
        fill_nxt  = fill;
        good_nxt  = good;
        bad_nxt   = bad;
        err_nxt   = 1'b0;
        inc_err   = 1'b0;
        inc_bit   = 1'b0;
        if (bus.din_valid) begin
            // History always takes the received bit so the checker re-aligns after slips.
            h_nxt = {bus.din, h[WIDTH-1:1]};
            unique case (state)
                HUNT: begin
                    if (fill != FILL_FULL) begin
                        fill_nxt = fill + 1'b1;
                    end else if (!mismatch && (tap_win != '0)) begin
                        if (good == GOOD_LAST) begin
                            state_nxt = LOCKED;
                            good_nxt  = '0;
                            bad_nxt   = '0;
                        end else begin
                            good_nxt = good + 1'b1;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
                LOCKED: begin
                    inc_bit = 1'b1;
                    if (mismatch) begin
                        err_nxt = 1'b1;
                        inc_err = 1'b1;
                        if (bad == BAD_LAST) begin
                            state_nxt = HUNT;
                            good_nxt  = '0;
                            bad_nxt   = '0;
                        end else begin
                            bad_nxt = bad + 1'b1;
                        end
                    end else begin
                        bad_nxt = '0;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Stage p1: FSM, history and error pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= HUNT;
            h      <= '0;
            fill   <= '0;
            good   <= '0;
            bad    <= '0;
            err_p1 <= 1'b0;
        end else begin
            state  <= state_nxt;
            h      <= h_nxt;
            fill   <= fill_nxt;
            good   <= good_nxt;
            bad    <= bad_nxt;
            err_p1 <= err_nxt;
        end
    end

    // Stage p1: statistics; a clear drops any same-cycle increment
    always_ff @(posedge clk) begin
        if (!rst || bus.clr) begin
            err_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            if (inc_err) err_cnt <= sat_inc_err(err_cnt);
            if (inc_bit) bit_cnt <= sat_inc_bit(bit_cnt);
        end
    end

    assign bus.locked  = (state == LOCKED);
    assign bus.err     = err_p1;
    assign bus.err_cnt = err_cnt;
    assign bus.bit_cnt = bit_cnt;
endmodule

// File: tb/tb_prbs_lfsr_checker.sv
// Bench for prbs_lfsr_checker: generator-driven and randomised streams compared against
// a reference model that predicts each bit from the list of bits received since reset.
module tb_prbs_lfsr_checker;
    localparam int         WIDTH     = 8;
    localparam logic [7:0] TAPS      = 8'b10111000;
    localparam int         LOCK_GOOD = 16;
    localparam int         LOSS_ERR  = 4;
    localparam int         CNT_W     = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prbs_lfsr_checker_if #(.CNT_W(CNT_W)) bus ();

    prbs_lfsr_checker #(
        .WIDTH(WIDTH), .TAPS(TAPS), .LOCK_GOOD(LOCK_GOOD),
        .LOSS_ERR(LOSS_ERR), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit               hist[$];
    bit [WIDTH-1:0]   tap_mask = TAPS;
    bit               m_locked;
    int               m_good, m_bad;
    bit               m_err;
    logic [CNT_W-1:0] m_err_cnt;
    logic [31:0]      m_bit_cnt;
    bit [7:0]         gen;
    int               golden_lock = -1;

    task automatic gen_bit(output bit b);
        b   = gen[7] ^ gen[5] ^ gen[4] ^ gen[3];
        gen = {b, gen[7:1]};
    endtask

    // Prediction = XOR of earlier received bits at the offsets the tap mask selects.
    task automatic model_pred(output bit p, output bit nz);
        p  = 1'b0;
        nz = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (tap_mask[k]) begin
                int off;
                bit t;
                off = WIDTH - k;
                t   = (hist.size() >= off) ? hist[hist.size() - off] : 1'b0;
                p   = p ^ t;
                nz  = nz | t;
            end
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_locked  = 1'b0;
        m_good    = 0;
        m_bad     = 0;
        m_err     = 1'b0;
        m_err_cnt = '0;
        m_bit_cnt = '0;
    endtask

    task automatic model_cycle(input bit v, input bit d, input bit c);
        bit p, nz, e;
        e = 1'b0;
        if (v) begin
            model_pred(p, nz);
            if (!m_locked) begin
                if (hist.size() >= WIDTH) begin
                    if (d == p && nz) begin
                        m_good++;
                        if (m_good == LOCK_GOOD) begin
                            m_locked = 1'b1;
                            m_good   = 0;
                            m_bad    = 0;
                        end
                    end else begin
                        m_good = 0;
                    end
                end
            end else begin
                if (!c && m_bit_cnt != 32'hFFFF_FFFF) m_bit_cnt = m_bit_cnt + 1;
                if (d != p) begin
                    e = 1'b1;
                    if (!c && m_err_cnt != {CNT_W{1'b1}}) m_err_cnt = m_err_cnt + 1;
                    m_bad++;
                    if (m_bad == LOSS_ERR) begin
                        m_locked = 1'b0;
                        m_good   = 0;
                        m_bad    = 0;
                    end
                end else begin
                    m_bad = 0;
                end
            end
            hist.push_back(d);
        end
        if (c) begin
            m_err_cnt = '0;
            m_bit_cnt = '0;
        end
        m_err = e;
    endtask

    task automatic tick(input bit v, input bit d, input bit c);
        bus.din_valid = v;
        bus.din       = d;
        bus.clr       = c;
        model_cycle(v, d, c);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit c);
        rst           = 1'b0;
        bus.din_valid = 1'b1;
        bus.din       = 1'b1;
        bus.clr       = c;
        repeat (2) @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.din_valid = 1'b0;
        bus.clr       = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0b expected 0", bus.locked); end
        n_tests++;
        if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", bus.err); end
        n_tests++;
        if (bus.err_cnt !== '0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", bus.err_cnt); end
        n_tests++;
        if (bus.bit_cnt !== '0) begin n_fail++; $display("FAIL reset_bit_cnt: got %0d expected 0", bus.bit_cnt); end
        n_tests++;
    endtask

    task automatic test_golden();
        bit b;
        int lock_at = -1, m_lock_at = -1;
        do_reset(1'b0);
        gen = 8'h80;
        for (int i = 1; i <= 1000; i++) begin
            gen_bit(b);
            tick(1'b1, b, 1'b0);
            if (m_lock_at < 0 && m_locked) m_lock_at = i;
            if (lock_at < 0 && bus.locked === 1'b1) lock_at = i;
            if (bus.locked !== m_locked) begin n_fail++; $display("FAIL golden_locked bit %0d: got %0b expected %0b", i, bus.locked, m_locked); end
            n_tests++;
            if (bus.err !== 1'b0) begin n_fail++; $display("FAIL golden_err bit %0d: got %0b expected 0", i, bus.err); end
            n_tests++;
        end
        golden_lock = m_lock_at;
        if (lock_at != m_lock_at) begin n_fail++; $display("FAIL golden_lock_index: got %0d expected %0d", lock_at, m_lock_at); end
        n_tests++;
        if (lock_at < WIDTH + LOCK_GOOD) begin n_fail++; $display("FAIL golden_lock_min: got %0d expected >= %0d", lock_at, WIDTH + LOCK_GOOD); end
        n_tests++;
        if (bus.err_cnt !== '0) begin n_fail++; $display("FAIL golden_err_cnt: got %0d expected 0", bus.err_cnt); end
        n_tests++;
        if (bus.bit_cnt !== 32'(1000 - m_lock_at)) begin n_fail++; $display("FAIL golden_bit_cnt: got %0d expected %0d", bus.bit_cnt, 1000 - m_lock_at); end
        n_tests++;
    endtask

    task automatic test_single_error();
        bit b;
        int errs[$];
        int exp_pos[5] = '{200, 201, 203, 204, 205};
        do_reset(1'b0);
        gen = 8'h80;
        for (int i = 1; i <= 1000; i++) begin
            gen_bit(b);
            if (i == 200) b = ~b;
            tick(1'b1, b, 1'b0);
            if (bus.err === 1'b1) errs.push_back(i);
            if (bus.err !== m_err) begin n_fail++; $display("FAIL single_err bit %0d: got %0b expected %0b", i, bus.err, m_err); end
            n_tests++;
        end
        if (errs.size() != 5) begin n_fail++; $display("FAIL single_pulse_count: got %0d expected 5", errs.size()); end
        n_tests++;
        for (int k = 0; k < 5 && k < errs.size(); k++) begin
            if (errs[k] != exp_pos[k]) begin n_fail++; $display("FAIL single_pulse_pos %0d: got %0d expected %0d", k, errs[k], exp_pos[k]); end
            n_tests++;
        end
        if (bus.err_cnt !== 16'd5) begin n_fail++; $display("FAIL single_err_cnt: got %0d expected 5", bus.err_cnt); end
        n_tests++;
        if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL single_locked: got %0b expected 1", bus.locked); end
        n_tests++;
    endtask

    task automatic test_zero_stream();
        do_reset(1'b0);
        for (int i = 1; i <= 64; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL zero_locked bit %0d: got %0b expected 0", i, bus.locked); end
            n_tests++;
        end
        if (bus.err_cnt !== '0) begin n_fail++; $display("FAIL zero_err_cnt: got %0d expected 0", bus.err_cnt); end
        n_tests++;
    endtask

    task automatic test_loss_of_lock();
        bit b, p, nz;
        int cnt = 0, relock = -1, m_relock = -1;
        do_reset(1'b0);
        gen = 8'h80;
        while (bus.locked !== 1'b1 && cnt < 100) begin
            gen_bit(b);
            tick(1'b1, b, 1'b0);
            cnt++;
        end
        if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL loss_initial_lock: got %0b expected 1 within 100 bits", bus.locked); end
        n_tests++;
        for (int k = 1; k <= LOSS_ERR; k++) begin
            model_pred(p, nz);
            tick(1'b1, ~p, 1'b0);
            if (bus.locked !== (k < LOSS_ERR)) begin n_fail++; $display("FAIL loss_locked bad %0d: got %0b expected %0b", k, bus.locked, (k < LOSS_ERR)); end
            n_tests++;
            if (bus.err !== 1'b1) begin n_fail++; $display("FAIL loss_err bad %0d: got %0b expected 1", k, bus.err); end
            n_tests++;
        end
        if (bus.err_cnt !== 16'd4) begin n_fail++; $display("FAIL loss_err_cnt: got %0d expected 4", bus.err_cnt); end
        n_tests++;
        for (int i = 1; i <= 200 && (relock < 0 || m_relock < 0); i++) begin
            gen_bit(b);
            tick(1'b1, b, 1'b0);
            if (m_relock < 0 && m_locked) m_relock = i;
            if (relock < 0 && bus.locked === 1'b1) relock = i;
        end
        if (relock != m_relock) begin n_fail++; $display("FAIL loss_relock_index: got %0d expected %0d", relock, m_relock); end
        n_tests++;
        if (relock < LOCK_GOOD) begin n_fail++; $display("FAIL loss_relock_min: got %0d expected >= %0d", relock, LOCK_GOOD); end
        n_tests++;
    endtask

    task automatic test_gaps_and_clear();
        bit b;
        int lock_at = -1;
        do_reset(1'b0);
        gen = 8'h80;
        for (int i = 1; i <= 60; i++) begin
            gen_bit(b);
            tick(1'b1, b, 1'b0);
            if (lock_at < 0 && bus.locked === 1'b1) lock_at = i;
            for (int g = 0; g < 2; g++) begin
                tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                if (bus.err !== 1'b0) begin n_fail++; $display("FAIL gaps_idle_err bit %0d: got %0b expected 0", i, bus.err); end
                n_tests++;
                if (bus.locked !== m_locked || bus.bit_cnt !== m_bit_cnt) begin
                    n_fail++;
                    $display("FAIL gaps_idle_hold bit %0d: got locked=%0b bit_cnt=%0d expected locked=%0b bit_cnt=%0d",
                             i, bus.locked, bus.bit_cnt, m_locked, m_bit_cnt);
                end
                n_tests++;
            end
        end
        if (lock_at != golden_lock) begin n_fail++; $display("FAIL gaps_lock_index: got %0d expected %0d", lock_at, golden_lock); end
        n_tests++;
        gen_bit(b);
        tick(1'b1, ~b, 1'b0);
        if (bus.err !== 1'b1 || bus.err_cnt !== 16'd1) begin
            n_fail++; $display("FAIL clr_first_err: got err=%0b err_cnt=%0d expected err=1 err_cnt=1", bus.err, bus.err_cnt);
        end
        n_tests++;
        gen_bit(b);
        tick(1'b1, b, 1'b1);
        if (bus.err_cnt !== '0) begin n_fail++; $display("FAIL clr_wins: got %0d expected 0", bus.err_cnt); end
        n_tests++;
        if (bus.err !== 1'b1) begin n_fail++; $display("FAIL clr_err_kept: got %0b expected 1", bus.err); end
        n_tests++;
        gen_bit(b);
        tick(1'b1, b, 1'b0);
        if (bus.err !== 1'b0 || bus.err_cnt !== '0) begin
            n_fail++; $display("FAIL clr_quiet: got err=%0b err_cnt=%0d expected err=0 err_cnt=0", bus.err, bus.err_cnt);
        end
        n_tests++;
        gen_bit(b);
        tick(1'b1, b, 1'b0);
        if (bus.err !== 1'b1 || bus.err_cnt !== 16'd1) begin
            n_fail++; $display("FAIL clr_next_err: got err=%0b err_cnt=%0d expected err=1 err_cnt=1", bus.err, bus.err_cnt);
        end
        n_tests++;
    endtask

    task automatic test_random();
        bit b, v, c, d;
        int burst = 0;
        do_reset(1'b0);
        gen = 8'h80;
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 59) == 0);
            if (v) begin
                gen_bit(b);
                if (burst == 0 && $urandom_range(0, 399) == 0) burst = 6;
                if (burst > 0) begin
                    d = ~b;
                    burst--;
                end else begin
                    d = b ^ ($urandom_range(0, 79) == 0);
                end
            end else begin
                d = 1'($urandom_range(0, 1));
            end
            tick(v, d, c);
            if (bus.locked !== m_locked || bus.err !== m_err || bus.err_cnt !== m_err_cnt || bus.bit_cnt !== m_bit_cnt) begin
                n_fail++;
                $display("FAIL random cycle %0d: got locked=%0b err=%0b err_cnt=%0d bit_cnt=%0d expected %0b %0b %0d %0d",
                         i, bus.locked, bus.err, bus.err_cnt, bus.bit_cnt, m_locked, m_err, m_err_cnt, m_bit_cnt);
            end
            n_tests++;
        end
    endtask

    task automatic test_mid_reset();
        bit b;
        int lock_at = -1;
        gen = 8'h80;
        for (int i = 0; i < 80; i++) begin
            gen_bit(b);
            tick(1'b1, b, 1'b0);
        end
        do_reset(1'b1);
        if (bus.locked !== 1'b0 || bus.err !== 1'b0 || bus.err_cnt !== '0 || bus.bit_cnt !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got locked=%0b err=%0b err_cnt=%0d bit_cnt=%0d expected all 0",
                     bus.locked, bus.err, bus.err_cnt, bus.bit_cnt);
        end
        n_tests++;
        gen = 8'h80;
        for (int i = 1; i <= 100 && lock_at < 0; i++) begin
            gen_bit(b);
            tick(1'b1, b, 1'b0);
            if (bus.locked === 1'b1) lock_at = i;
        end
        if (lock_at != golden_lock) begin n_fail++; $display("FAIL mid_reset_relock: got %0d expected %0d", lock_at, golden_lock); end
        n_tests++;
    endtask

    initial begin
        rst           = 1'b0;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.clr       = 1'b0;
        model_reset();
        test_reset();
        test_golden();
        test_single_error();
        test_zero_stream();
        test_loss_of_lock();
        test_gaps_and_clear();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded 2000000 time units");
        $fatal(1);
    end
endmodule
